// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared types and constants for the 5-stage core.
//               regbits_t   - register-file index
//               hz_state_t  - hazard sequencer state encoding
//               HZ_WAIT_MAX - default dmem wait watchdog limit
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  // Register-file index (32 architectural registers, $0 hardwired to zero)
  typedef logic [4:0] regbits_t;

  // Hazard sequencer states
  typedef logic [1:0] hz_state_t;
  localparam hz_state_t c_HZ_RUN   = 2'd0;
  localparam hz_state_t c_HZ_DWAIT = 2'd1;
  localparam hz_state_t c_HZ_HALT  = 2'd2;

  // Default number of dmem wait cycles before the watchdog trips
  localparam int HZ_WAIT_MAX = 64;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/hazard_perf_counter.sv
`default_nettype none
// ============================================================================
// Module      : hazard_perf_counter
// Description : Two free-running wrap-around event counters for the hazard
//               sequencer (stall cycles and branch flushes). The module only
//               exists when HAZARD_PERF_EN is defined.
// Ports       : clk          in   core clock, rising edge
//               rst          in   asynchronous active-high reset
//               i_stall_inc  in   count one stall cycle
//               i_flush_inc  in   count one branch flush
//               o_stall_cnt  out  stall-cycle count  [PERF_W]
//               o_flush_cnt  out  branch-flush count [PERF_W]
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef HAZARD_PERF_EN
module hazard_perf_counter #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall_inc,
  input  logic              i_flush_inc,
  output logic [PERF_W-1:0] o_stall_cnt,
  output logic [PERF_W-1:0] o_flush_cnt
);

  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;

  // Counters wrap naturally at 2^PERF_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (i_stall_inc) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (i_flush_inc) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule : hazard_perf_counter
`endif
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_unit
// Description : Pipeline sequencer for the 5-stage core. Drives every pipeline
//               register enable/flush and pc_en. Resolves load-use stalls,
//               imem/dmem wait states, taken-branch flushes and halt, and runs
//               a dmem-wait watchdog.
//               Optional macro HAZARD_PERF_EN adds stall_cnt / flush_cnt.
// Ports       : CLK, RST (async, active-high)
//               ihit, dhit, exmem_memacc, idex_lw, idex_rt, ifid_rs, ifid_rt,
//               ifid_usert, branch_taken, exmem_halt            (inputs)
//               pc_en, ifid_en/flush, idex_en/flush, exmem_en/flush,
//               memwb_en, halt, mem_timeout                    (outputs)
//               stall_cnt, flush_cnt                 (HAZARD_PERF_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit
  import cpu_types_pkg::*;
#(
  parameter int WAIT_MAX = HZ_WAIT_MAX
`ifdef HAZARD_PERF_EN
  ,
  parameter int PERF_W   = 32
`endif
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     ihit,
  input  logic     dhit,
  input  logic     exmem_memacc,
  input  logic     idex_lw,
  input  regbits_t idex_rt,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  input  logic     ifid_usert,
  input  logic     branch_taken,
  input  logic     exmem_halt,
  output logic     pc_en,
  output logic     ifid_en,
  output logic     ifid_flush,
  output logic     idex_en,
  output logic     idex_flush,
  output logic     exmem_en,
  output logic     exmem_flush,
  output logic     memwb_en,
  output logic     halt,
  output logic     mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  localparam int                 c_CNT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(WAIT_MAX);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WAIT_MAX - 1);

  hz_state_t          r_state;
  hz_state_t          w_next_state;
  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               r_mem_timeout;

  logic w_wait;          // this cycle is spent waiting on dmem
  logic w_load_use;
  logic w_branch_flush;
  logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush;
  logic w_exmem_en, w_exmem_flush, w_memwb_en;

  // Load-use: a load into a nonzero register read by the IF/ID instruction
  assign w_load_use = idex_lw && (idex_rt != '0) &&
                      ((idex_rt == ifid_rs) || (ifid_usert && (idex_rt == ifid_rt)));

  // In DWAIT only dhit releases the wait; in RUN a new miss starts one
  assign w_wait = (r_state == c_HZ_DWAIT) ? !dhit :
                  (r_state == c_HZ_RUN)   ? (exmem_memacc && !dhit) : 1'b0;

  always_comb begin
    w_next_state   = r_state;
    w_branch_flush = 1'b0;
    w_pc_en        = 1'b0;
    w_ifid_en      = 1'b0;
    w_ifid_flush   = 1'b0;
    w_idex_en      = 1'b0;
    w_idex_flush   = 1'b0;
    w_exmem_en     = 1'b0;
    w_exmem_flush  = 1'b0;
    w_memwb_en     = 1'b0;
    case (r_state)
      c_HZ_RUN, c_HZ_DWAIT: begin
        if (exmem_halt && !w_wait) begin
          // Freeze and halt; older instructions have already written back
          w_next_state = c_HZ_HALT;
        end else if (w_wait) begin
          w_next_state = c_HZ_DWAIT;
        end else begin
          // Ordinary RUN decision (also applied on the dhit cycle of DWAIT)
          w_next_state = c_HZ_RUN;
          w_idex_en    = 1'b1;
          w_exmem_en   = 1'b1;
          w_memwb_en   = 1'b1;
          if (branch_taken) begin
            w_branch_flush = 1'b1;
            w_pc_en        = 1'b1;
            w_ifid_en      = 1'b1;
            w_ifid_flush   = 1'b1;
            w_idex_flush   = 1'b1;
            w_exmem_flush  = 1'b1;
          end else if (w_load_use) begin
            // Hold PC and IF/ID, inject one bubble into ID/EX
            w_idex_flush = 1'b1;
          end else if (!ihit) begin
            // No instruction fetched: bubble enters IF/ID
            w_ifid_en    = 1'b1;
            w_ifid_flush = 1'b1;
          end else begin
            w_pc_en   = 1'b1;
            w_ifid_en = 1'b1;
          end
        end
      end
      default: w_next_state = c_HZ_HALT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= c_HZ_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_wait) begin
        if (r_state == c_HZ_RUN) begin
          r_wait_cnt <= c_CNT_W'(1);
        end else if (r_wait_cnt != c_CNT_MAX) begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
        // Trip on the edge where the count reaches WAIT_MAX
        if ((r_state == c_HZ_DWAIT) && (r_wait_cnt >= c_CNT_LAST)) begin
          r_mem_timeout <= 1'b1;
        end
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  // All enables/flushes are forced low while reset is asserted
  assign pc_en       = w_pc_en       & ~RST;
  assign ifid_en     = w_ifid_en     & ~RST;
  assign ifid_flush  = w_ifid_flush  & ~RST;
  assign idex_en     = w_idex_en     & ~RST;
  assign idex_flush  = w_idex_flush  & ~RST;
  assign exmem_en    = w_exmem_en    & ~RST;
  assign exmem_flush = w_exmem_flush & ~RST;
  assign memwb_en    = w_memwb_en    & ~RST;
  assign halt        = (r_state == c_HZ_HALT);
  assign mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_EN
  logic w_stall_inc;
  assign w_stall_inc = (r_state != c_HZ_HALT) && !w_pc_en;

  hazard_perf_counter #(
    .PERF_W (PERF_W)
  ) u_perf (
    .clk         (CLK),
    .rst         (RST),
    .i_stall_inc (w_stall_inc),
    .i_flush_inc (w_branch_flush),
    .o_stall_cnt (stall_cnt),
    .o_flush_cnt (flush_cnt)
  );
`endif

endmodule : hazard_ctrl_unit
`default_nettype wire
